// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for blocks that front the 4-bit ALU.
package alu_pkg;

    localparam int OPW   = 4;
    localparam int CODEW = 3;
    localparam int RESW  = 9;

    localparam logic [CODEW-1:0] OP_ADD = 3'd0;
    localparam logic [CODEW-1:0] OP_SUB = 3'd1;
    localparam logic [CODEW-1:0] OP_AND = 3'd2;
    localparam logic [CODEW-1:0] OP_XOR = 3'd3;
    localparam logic [CODEW-1:0] OP_OR  = 3'd4;
    localparam logic [CODEW-1:0] OP_ROL = 3'd5;
    localparam logic [CODEW-1:0] OP_ROR = 3'd6;
    localparam logic [CODEW-1:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the requester that was not served last wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic grant0,
    output logic grant1
);

    always_comb begin
        grant0 = valid0 & (~valid1 | last);
        grant1 = valid1 & (~valid0 | ~last);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// registered operands, fixed settle time, result returned to the winner only.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_in1,
    input  logic [OPW-1:0]  req0_in2,
    input  logic [CODEW-1:0] req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_in1,
    input  logic [OPW-1:0]  req1_in2,
    input  logic [CODEW-1:0] req1_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [RESW-1:0] rsp_data,
    output logic [OPW-1:0]  alu_in1,
    output logic [OPW-1:0]  alu_in2,
    output logic [CODEW-1:0] alu_op,
    input  logic [RESW-1:0] alu_out
);

    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    state_t        state, state_n;
    logic          last;
    logic          owner;
    logic [CW-1:0] cnt;
    logic          grant0, grant1;
    logic          accept, capture, rsp_take;

    rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .last   (last),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    always_comb begin
        state_n    = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_take   = 1'b0;
        case (state)
            IDLE: begin
                // Masked during reset so a requester never sees a handshake that is then discarded.
                req0_ready = grant0 & ~rst;
                req1_ready = grant1 & ~rst;
                if (grant0 | grant1) begin
                    accept  = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                rsp_take = owner ? rsp1_ready : rsp0_ready;
                if (rsp_take) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_op     <= '0;
            rsp_data   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            if (accept) begin
                owner   <= grant1;
                last    <= grant1;
                alu_in1 <= grant1 ? req1_in1 : req0_in1;
                alu_in2 <= grant1 ? req1_in2 : req0_in2;
                alu_op  <= grant1 ? req1_op  : req0_op;
                cnt     <= CNT_LOAD;
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) begin
                rsp_data   <= alu_out;
                rsp0_valid <= ~owner;
                rsp1_valid <= owner;
            end
            if (rsp_take) begin
                rsp0_valid <= 1'b0;
                rsp1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: SETTLE=1 and SETTLE=3 instances, each driving a behavioural ALU.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         vecs = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [2:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [8:0] rsp_data, alu_out;
    logic [3:0] alu_in1, alu_in2;
    logic [2:0] alu_op;

    logic       s3_req0_valid, s3_req0_ready, s3_req1_valid, s3_req1_ready;
    logic [3:0] s3_req0_in1, s3_req0_in2, s3_req1_in1, s3_req1_in2;
    logic [2:0] s3_req0_op, s3_req1_op;
    logic       s3_rsp0_valid, s3_rsp0_ready, s3_rsp1_valid, s3_rsp1_ready;
    logic [8:0] s3_rsp_data, s3_alu_out;
    logic [3:0] s3_alu_in1, s3_alu_in2;
    logic [2:0] s3_alu_op;

    function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] a5, b5;
        logic [7:0] aa, m;
        a5 = {1'b0, a};
        b5 = {1'b0, b};
        m  = {4'd0, a} * {4'd0, b};
        case (op)
            3'd0: return {4'd0, a5 + b5};
            3'd1: return {4'd0, a5 - b5};
            3'd2: return {5'd0, a & b};
            3'd3: return {5'd0, a ^ b};
            3'd4: return {5'd0, a | b};
            3'd5: begin aa = {a, a} << b[1:0]; return {5'd0, aa[7:4]}; end
            3'd6: begin aa = {a, a} >> b[1:0]; return {5'd0, aa[3:0]}; end
            default: return {1'b0, m};
        endcase
    endfunction

    assign alu_out    = alu_fn(alu_in1, alu_in2, alu_op);
    assign s3_alu_out = alu_fn(s3_alu_in1, s3_alu_in2, s3_alu_op);

    alu_arbiter #(.SETTLE(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out)
    );

    alu_arbiter #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(s3_req0_valid), .req0_ready(s3_req0_ready),
        .req0_in1(s3_req0_in1), .req0_in2(s3_req0_in2), .req0_op(s3_req0_op),
        .req1_valid(s3_req1_valid), .req1_ready(s3_req1_ready),
        .req1_in1(s3_req1_in1), .req1_in2(s3_req1_in2), .req1_op(s3_req1_op),
        .rsp0_valid(s3_rsp0_valid), .rsp0_ready(s3_rsp0_ready),
        .rsp1_valid(s3_rsp1_valid), .rsp1_ready(s3_rsp1_ready),
        .rsp_data(s3_rsp_data),
        .alu_in1(s3_alu_in1), .alu_in2(s3_alu_in2), .alu_op(s3_alu_op), .alu_out(s3_alu_out)
    );

    // Advance past the next rising edge; inputs are driven in the following 1 ns window.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        vecs++; if (rsp0_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp0_valid: got %0d want 0", rsp0_valid); end
        vecs++; if (rsp1_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp1_valid: got %0d want 0", rsp1_valid); end
        vecs++; if (rsp_data !== 9'd0) begin errs++; $display("FAIL reset_rsp_data: got %0d want 0", rsp_data); end
        vecs++; if ({alu_in1, alu_in2, alu_op} !== 11'd0) begin errs++; $display("FAIL reset_alu_regs: got %0h want 0", {alu_in1, alu_in2, alu_op}); end
        vecs++; if ({req0_ready, req1_ready} !== 2'b00) begin errs++; $display("FAIL reset_readies: got %b want 00", {req0_ready, req1_ready}); end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_in1 = 4'd9; req0_in2 = 4'd8; req0_op = 3'd0; rsp0_ready = 1'b1;
        #1;
        vecs++; if (req0_ready !== 1'b1) begin errs++; $display("FAIL single_ready: got %0d want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        vecs++; if ({alu_in1, alu_in2, alu_op} !== {4'd9, 4'd8, 3'd0}) begin errs++; $display("FAIL single_alu_regs: got %0d/%0d/%0d want 9/8/0", alu_in1, alu_in2, alu_op); end
        vecs++; if (rsp0_valid !== 1'b0) begin errs++; $display("FAIL single_early_valid: got %0d want 0", rsp0_valid); end
        tick(); #1;
        vecs++; if (rsp0_valid !== 1'b1) begin errs++; $display("FAIL single_rsp0_valid: got %0d want 1", rsp0_valid); end
        vecs++; if (rsp_data !== 9'd17) begin errs++; $display("FAIL single_rsp_data: got %0d want 17", rsp_data); end
        vecs++; if (rsp1_valid !== 1'b0) begin errs++; $display("FAIL single_rsp1_valid: got %0d want 0", rsp1_valid); end
        tick(); #1;
        vecs++; if (rsp0_valid !== 1'b0) begin errs++; $display("FAIL single_rsp_drop: got %0d want 0", rsp0_valid); end
    endtask

    task automatic test_tie();
        int         nrsp;
        logic       busy;
        logic [8:0] got [2];
        int         who [2];
        nrsp = 0; busy = 1'b0;
        got[0] = '0; got[1] = '0; who[0] = -1; who[1] = -1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_in1 = 4'd15; req0_in2 = 4'd15; req0_op = 3'd7;
        req1_valid = 1'b1; req1_in1 = 4'd3;  req1_in2 = 4'd5;  req1_op = 3'd1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        vecs++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("FAIL tie_first_grant: got %b want 10", {req0_ready, req1_ready}); end
        for (int c = 0; c < 20 && nrsp < 2; c++) begin
            logic a0, a1, t0, t1;
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            t0 = rsp0_valid & rsp0_ready;
            t1 = rsp1_valid & rsp1_ready;
            if (busy) begin
                vecs++; if (req1_ready !== 1'b0) begin errs++; $display("FAIL tie_ready_while_busy: got %0d want 0", req1_ready); end
            end
            if (t0 | t1) begin
                got[nrsp] = rsp_data;
                who[nrsp] = t1 ? 1 : 0;
                nrsp++;
            end
            tick();
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
            if (a0 | a1) busy = 1'b1;
            else if (t0 | t1) busy = 1'b0;
            #1;
        end
        vecs++; if (nrsp !== 2) begin errs++; $display("FAIL tie_timeout: got %0d responses want 2", nrsp); end
        vecs++; if (who[0] !== 0 || got[0] !== 9'd225) begin errs++; $display("FAIL tie_first_rsp: got owner %0d data %0d want owner 0 data 225", who[0], got[0]); end
        vecs++; if (who[1] !== 1 || got[1] !== 9'd30) begin errs++; $display("FAIL tie_second_rsp: got owner %0d data %0d want owner 1 data 30", who[1], got[1]); end
    endtask

    task automatic test_fairness();
        int ng;
        int g [6];
        ng = 0;
        for (int i = 0; i < 6; i++) g[i] = -1;
        req0_valid = 1'b1; req0_in1 = 4'd2; req0_in2 = 4'd3; req0_op = 3'd0;
        req1_valid = 1'b1; req1_in1 = 4'd7; req1_in2 = 4'd1; req1_op = 3'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            if (req0_valid & req0_ready) begin g[ng] = 0; ng++; end
            else if (req1_valid & req1_ready) begin g[ng] = 1; ng++; end
            if (rsp0_valid) begin
                vecs++; if (rsp_data !== 9'd5) begin errs++; $display("FAIL fair_rsp0_data: got %0d want 5", rsp_data); end
            end
            if (rsp1_valid) begin
                vecs++; if (rsp_data !== 9'd8) begin errs++; $display("FAIL fair_rsp1_data: got %0d want 8", rsp_data); end
            end
            tick(); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (rsp0_valid | rsp1_valid) begin
                tick(); #1;
                break;
            end
            tick(); #1;
        end
        for (int i = 0; i < 6; i++) begin
            vecs++; if (g[i] !== i % 2) begin errs++; $display("FAIL fair_grant_%0d: got %0d want %0d", i, g[i], i % 2); end
        end
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_in1 = 4'hC; req1_in2 = 4'hA; req1_op = 3'd2;
        rsp1_ready = 1'b0;
        #1;
        vecs++; if (req1_ready !== 1'b1) begin errs++; $display("FAIL bp_accept: got %0d want 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_in1 = 4'd1; req0_in2 = 4'd1; req0_op = 3'd0;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (rsp1_valid) break;
            tick(); #1;
        end
        vecs++; if (rsp1_valid !== 1'b1) begin errs++; $display("FAIL bp_rsp_timeout: got %0d want 1", rsp1_valid); end
        for (int c = 0; c < 5; c++) begin
            vecs++; if (rsp1_valid !== 1'b1 || rsp_data !== 9'd8) begin errs++; $display("FAIL bp_stall_hold: got valid %0d data %0d want 1/8", rsp1_valid, rsp_data); end
            vecs++; if ({req0_ready, req1_ready} !== 2'b00) begin errs++; $display("FAIL bp_stall_ready: got %b want 00", {req0_ready, req1_ready}); end
            tick(); #1;
        end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        #1;
        vecs++; if (rsp1_valid !== 1'b0) begin errs++; $display("FAIL bp_rsp_drop: got %0d want 0", rsp1_valid); end
        vecs++; if (req0_ready !== 1'b1) begin errs++; $display("FAIL bp_idle_reentry: got %0d want 1", req0_ready); end
        req0_valid = 1'b0;
        #1;
    endtask

    task automatic test_settle3();
        s3_req0_valid = 1'b1; s3_req0_in1 = 4'hA; s3_req0_in2 = 4'h6; s3_req0_op = 3'd3;
        s3_rsp0_ready = 1'b1;
        #1;
        vecs++; if (s3_req0_ready !== 1'b1) begin errs++; $display("FAIL s3_accept: got %0d want 1", s3_req0_ready); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            s3_req0_valid = 1'b0;
            #1;
            if (k == 1) begin
                vecs++; if ({s3_alu_in1, s3_alu_in2, s3_alu_op} !== {4'hA, 4'h6, 3'd3}) begin errs++; $display("FAIL s3_alu_regs: got %0h/%0h/%0d want a/6/3", s3_alu_in1, s3_alu_in2, s3_alu_op); end
            end
            if (k < 4) begin
                vecs++; if (s3_rsp0_valid !== 1'b0) begin errs++; $display("FAIL s3_early_valid_A+%0d: got %0d want 0", k, s3_rsp0_valid); end
            end else begin
                vecs++; if (s3_rsp0_valid !== 1'b1 || s3_rsp_data !== 9'd12) begin errs++; $display("FAIL s3_rsp_A+4: got valid %0d data %0d want 1/12", s3_rsp0_valid, s3_rsp_data); end
            end
        end
        tick(); #1;
    endtask

    task automatic test_reset_exec();
        req0_valid = 1'b1; req0_in1 = 4'd5; req0_in2 = 4'd2; req0_op = 3'd4;
        req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick(); #1;
        vecs++; if ({alu_in1, alu_in2, alu_op} !== 11'd0) begin errs++; $display("FAIL rexec_alu_regs: got %0h want 0", {alu_in1, alu_in2, alu_op}); end
        vecs++; if (rsp_data !== 9'd0) begin errs++; $display("FAIL rexec_rsp_data: got %0d want 0", rsp_data); end
        vecs++; if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0000) begin errs++; $display("FAIL rexec_flags: got %b want 0000", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}); end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            vecs++; if (rsp0_valid !== 1'b0) begin errs++; $display("FAIL rexec_no_rsp: got %0d want 0", rsp0_valid); end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        vecs++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("FAIL rexec_tie: got %b want 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); #1;
    endtask

    initial begin
        req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_op = '0;
        req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        s3_req0_valid = 1'b0; s3_req0_in1 = '0; s3_req0_in2 = '0; s3_req0_op = '0;
        s3_req1_valid = 1'b0; s3_req1_in1 = '0; s3_req1_in2 = '0; s3_req1_op = '0;
        s3_rsp0_ready = 1'b0; s3_rsp1_ready = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_backpressure();
        test_settle3();
        test_reset_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 4-bit ALU between two requesters. Each requester has a valid/ready command channel and a valid/ready response channel. The block arbitrates round-robin and registers the winning operands onto the ALU inputs. It waits a fixed settle time, captures the 9-bit result, and returns it to the winning requester only. It sits between the ALU and its two clients.

## Interface
- SETTLE, default 1, number of cycles the ALU inputs are held before the result is captured (≥1).
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0_valid / req1_valid  input  1  command offered by requester 0 / 1.
- req0_ready / req1_ready  output  1  command accepted this cycle.
- req0_in1, req0_in2 / req1_in1, req1_in2  input  4  operands.
- req0_op / req1_op  input  3  opcode: 0 add, 1 sub, 2 and, 3 xor, 4 or, 5 rol, 6 ror, 7 mul.
- rsp0_valid / rsp1_valid  output  1  result available for requester 0 / 1.
- rsp0_ready / rsp1_ready  input  1  requester takes the result.
- rsp_data  output  9  result word, shared by both response channels; meaningful only while an rspN_valid is high.
- alu_in1, alu_in2  output  4  registered operands to the ALU.
- alu_op  output  3  registered opcode to the ALU.
- alu_out  input  9  ALU result (combinational from alu_in*/alu_op).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = 1 only for the arbitration winner, and only when that requester's reqN_valid is high.
  - Winner: if only one requester is valid, it wins. If both are valid, the requester not equal to the last-served requester (register `last`) wins.
  - On accept: latch in1/in2/op into alu_in*/alu_op, latch owner = winner, set `last` = winner, load the settle counter with SETTLE−1, go to EXEC.
- EXEC:
  - No readies are asserted; alu_* stay stable.
  - When the counter is 0, capture alu_out into rsp_data and go to RESP. Otherwise decrement the counter.
- RESP:
  - rsp[owner]_valid = 1, and the other rsp valid is 0. rsp_data and alu_* are held.
  - When rsp[owner]_ready is 1, drop valid and go to IDLE. A new command cannot be accepted in this same cycle.
- Result width rules:
  - rsp_data is alu_out verbatim. Add and sub results are zero-extended from 5 bits; logic and rotate results from 4 bits; mul from 8 bits.
  - The arbiter does no arithmetic of its own.
- Stalled requesters: a requester that loses arbitration keeps valid high and its operands stable. It is served at the next IDLE.
- rspN_ready while rspN_valid is low is ignored.
- Reset:
  - Clears all outputs to 0 and sets state to IDLE.
  - Sets `last` = 1, so requester 0 wins the first tie.
  - Reset mid-operation discards the in-flight command; no response is issued for it.

## Timing
- Cycle definitions:
  - Cycle A: accept cycle (reqN_valid & reqN_ready).
  - Cycle A+1: alu_* hold the new values.
  - Cycle A+SETTLE: rsp_data is captured at the end of this cycle.
  - Cycle A+SETTLE+1: rspN_valid first high.
- Minimum spacing between accepts: SETTLE+2 cycles, reached when the response is taken the cycle it appears.
- readies are combinational from state, `last` and the reqN_valid inputs. There is no combinational path from rspN_ready to any output in the same cycle.
- All other outputs are registered.

## Structure
- Shared package alu_pkg holds:
  - Opcode localparams OP_ADD…OP_MUL (3-bit).
  - State encoding IDLE/EXEC/RESP.
  - Width constants OPW=4, CODEW=3, RESW=9.
- One sub-module is natural: rr_arb2.
  - Two-input round-robin grant from (valid0, valid1, last).
  - Purely combinational; reused by other shared-resource blocks.
- The FSM, counter and datapath registers stay in alu_arbiter.

## Test plan
- Single request, SETTLE=1:
  - Stimulus: req0 add 9+8 at cycle 0, rsp0_ready held high.
  - Required: req0_ready=1 at cycle 0; alu_in1=9, alu_in2=8, alu_op=0 at cycle 1; rsp0_valid=1 with rsp_data=17 at cycle 2; rsp1_valid stays 0.
- Tie after reset:
  - Stimulus: both requesters valid at cycle 0; req0 mul 15×15, req1 sub 3−5.
  - Required: req0 is served first with rsp_data=225; req1 is then served with rsp_data=5'b11110 zero-extended (30).
  - Required: req1_ready is never high while state≠IDLE.
- Round-robin fairness:
  - Stimulus: both requesters held continuously valid for 6 grants.
  - Required: grants alternate 0,1,0,1,0,1.
- Response backpressure:
  - Stimulus: rsp1_ready held low for 5 cycles.
  - Required: rsp1_valid and rsp_data are stable throughout; no reqN_ready during the stall; IDLE is re-entered the cycle after rsp1_ready=1.
- SETTLE=3:
  - Stimulus: xor 4'hA ^ 4'h6.
  - Required: rsp valid at A+4 with rsp_data=12.
- Reset in EXEC:
  - Stimulus: assert rst one cycle after accept.
  - Required: all outputs are 0 the next cycle; no rsp_valid for the discarded command; the next tie goes to requester 0.
